// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM pipeline register, data-memory handshake,
// store lane alignment, load extraction and the MEM/WB bundle.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        EX_valid,
  input  logic        EX_MemRead,
  input  logic        EX_MemWrite,
  input  logic        EX_MemtoReg,
  input  logic        EX_regWrite,
  input  logic [2:0]  EX_funct3,
  input  logic [31:0] EX_alu_out,
  input  logic [31:0] EX_rs2_data,
  input  logic [4:0]  EX_rd_addr,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_di,
  input  logic [31:0] dm_do,
  input  logic        dm_ready,
  output logic        mem_stall,
  output logic        mem_misalign,
  output logic        MEM_MemtoReg,
  output logic        MEM_regWrite,
  output logic [31:0] MEM_rd_data,
  output logic [31:0] MEM_Dout,
  output logic [4:0]  MEM_rd_addr
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state_q, state_d;

  // EX/MEM register (P); misaligned ops are stored with controls cleared
  logic            p_memread_q, p_memread_d;
  logic            p_memtoreg_q, p_memtoreg_d;
  logic            p_regwrite_q, p_regwrite_d;
  logic [2:0]      p_funct3_q, p_funct3_d;
  logic [XLEN-1:0] p_alu_out_q, p_alu_out_d;
  logic [AW-1:0]   p_rd_addr_q, p_rd_addr_d;

  logic            dm_req_q, dm_req_d;
  logic            dm_we_q, dm_we_d;
  logic [3:0]      dm_be_q, dm_be_d;
  logic [XLEN-1:0] dm_addr_q, dm_addr_d;
  logic [XLEN-1:0] dm_di_q, dm_di_d;
  logic            mem_misalign_q, mem_misalign_d;

  logic            mem_memtoreg_q, mem_memtoreg_d;
  logic            mem_regwrite_q, mem_regwrite_d;
  logic [XLEN-1:0] mem_rd_data_q, mem_rd_data_d;
  logic [XLEN-1:0] mem_dout_q, mem_dout_d;
  logic [AW-1:0]   mem_rd_addr_q, mem_rd_addr_d;

  logic            capture;
  logic            ex_is_mem, ex_aligned, ex_issue, ex_misalign;
  logic [1:0]      ex_a;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_di;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;

  assign mem_stall = (state_q == BUSY) & ~dm_ready;
  assign capture   = ~mem_stall;

  // Alignment check and store lane steering for the incoming EX op
  always_comb begin
    ex_a        = EX_alu_out[1:0];
    ex_is_mem   = EX_valid & (EX_MemRead | EX_MemWrite);
    ex_aligned  = 1'b1;
    if (EX_funct3[1])      ex_aligned = (ex_a == 2'b00);
    else if (EX_funct3[0]) ex_aligned = ~ex_a[0];
    ex_issue    = ex_is_mem & ex_aligned;
    ex_misalign = ex_is_mem & ~ex_aligned;
    st_be       = 4'b1111;
    st_di       = '0;
    if (EX_MemWrite) begin
      if (EX_funct3[1]) begin
        st_di = EX_rs2_data;
      end else if (EX_funct3[0]) begin
        st_di = {2{EX_rs2_data[15:0]}};
        st_be = ex_a[1] ? 4'b1100 : 4'b0011;
      end else begin
        st_di = {4{EX_rs2_data[7:0]}};
        st_be = 4'b0001 << ex_a;
      end
    end
  end

  // Load extraction from dm_do using the captured address offset
  always_comb begin
    case (p_alu_out_q[1:0])
      2'b00:   ld_byte = dm_do[7:0];
      2'b01:   ld_byte = dm_do[15:8];
      2'b10:   ld_byte = dm_do[23:16];
      default: ld_byte = dm_do[31:24];
    endcase
    ld_half = p_alu_out_q[1] ? dm_do[31:16] : dm_do[15:0];
    if (p_funct3_q[1])
      ld_data = dm_do;
    else if (p_funct3_q[0])
      ld_data = p_funct3_q[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
    else
      ld_data = p_funct3_q[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
  end

  // FSM next state: every capture edge re-decides BUSY vs IDLE
  always_comb begin
    state_d = state_q;
    if (capture) state_d = ex_issue ? BUSY : IDLE;
  end

  // Next values of P, request outputs and the MEM/WB bundle
  always_comb begin
    p_memread_d    = p_memread_q;
    p_memtoreg_d   = p_memtoreg_q;
    p_regwrite_d   = p_regwrite_q;
    p_funct3_d     = p_funct3_q;
    p_alu_out_d    = p_alu_out_q;
    p_rd_addr_d    = p_rd_addr_q;
    dm_req_d       = dm_req_q;
    dm_we_d        = dm_we_q;
    dm_be_d        = dm_be_q;
    dm_addr_d      = dm_addr_q;
    dm_di_d        = dm_di_q;
    mem_misalign_d = 1'b0;
    mem_memtoreg_d = 1'b0;
    mem_regwrite_d = 1'b0;
    mem_rd_data_d  = '0;
    mem_dout_d     = '0;
    mem_rd_addr_d  = '0;
    if (capture) begin
      p_memread_d    = EX_valid & EX_MemRead & ~ex_misalign;
      p_memtoreg_d   = EX_valid & EX_MemtoReg;
      p_regwrite_d   = EX_valid & EX_regWrite & ~ex_misalign;
      p_funct3_d     = EX_valid ? EX_funct3 : 3'b000;
      p_alu_out_d    = EX_valid ? EX_alu_out : '0;
      p_rd_addr_d    = EX_valid ? EX_rd_addr : '0;
      dm_req_d       = ex_issue;
      dm_we_d        = ex_issue & EX_MemWrite;
      dm_be_d        = ex_issue ? st_be : 4'b0000;
      dm_addr_d      = ex_issue ? {EX_alu_out[XLEN-1:2], 2'b00} : '0;
      dm_di_d        = ex_issue ? st_di : '0;
      mem_misalign_d = ex_misalign;
      mem_memtoreg_d = p_memtoreg_q;
      mem_regwrite_d = p_regwrite_q;
      mem_rd_data_d  = p_alu_out_q;
      mem_dout_d     = p_memread_q ? ld_data : '0;
      mem_rd_addr_d  = p_rd_addr_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Pipeline and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_memread_q    <= 1'b0;
      p_memtoreg_q   <= 1'b0;
      p_regwrite_q   <= 1'b0;
      p_funct3_q     <= 3'b000;
      p_alu_out_q    <= '0;
      p_rd_addr_q    <= '0;
      dm_req_q       <= 1'b0;
      dm_we_q        <= 1'b0;
      dm_be_q        <= 4'b0000;
      dm_addr_q      <= '0;
      dm_di_q        <= '0;
      mem_misalign_q <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_rd_data_q  <= '0;
      mem_dout_q     <= '0;
      mem_rd_addr_q  <= '0;
    end else begin
      p_memread_q    <= p_memread_d;
      p_memtoreg_q   <= p_memtoreg_d;
      p_regwrite_q   <= p_regwrite_d;
      p_funct3_q     <= p_funct3_d;
      p_alu_out_q    <= p_alu_out_d;
      p_rd_addr_q    <= p_rd_addr_d;
      dm_req_q       <= dm_req_d;
      dm_we_q        <= dm_we_d;
      dm_be_q        <= dm_be_d;
      dm_addr_q      <= dm_addr_d;
      dm_di_q        <= dm_di_d;
      mem_misalign_q <= mem_misalign_d;
      mem_memtoreg_q <= mem_memtoreg_d;
      mem_regwrite_q <= mem_regwrite_d;
      mem_rd_data_q  <= mem_rd_data_d;
      mem_dout_q     <= mem_dout_d;
      mem_rd_addr_q  <= mem_rd_addr_d;
    end
  end

  assign dm_req       = dm_req_q;
  assign dm_we        = dm_we_q;
  assign dm_be        = dm_be_q;
  assign dm_addr      = dm_addr_q;
  assign dm_di        = dm_di_q;
  assign mem_misalign = mem_misalign_q;
  assign MEM_MemtoReg = mem_memtoreg_q;
  assign MEM_regWrite = mem_regwrite_q;
  assign MEM_rd_data  = mem_rd_data_q;
  assign MEM_Dout     = mem_dout_q;
  assign MEM_rd_addr  = mem_rd_addr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads, stores, wait states,
// misalignment and reset during an outstanding access.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        EX_valid, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_regWrite;
  logic [2:0]  EX_funct3;
  logic [31:0] EX_alu_out, EX_rs2_data;
  logic [4:0]  EX_rd_addr;
  logic        dm_req, dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_di, dm_do;
  logic        dm_ready, mem_stall, mem_misalign;
  logic        MEM_MemtoReg, MEM_regWrite;
  logic [31:0] MEM_rd_data, MEM_Dout;
  logic [4:0]  MEM_rd_addr;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .EX_valid(EX_valid), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_MemtoReg(EX_MemtoReg), .EX_regWrite(EX_regWrite), .EX_funct3(EX_funct3),
    .EX_alu_out(EX_alu_out), .EX_rs2_data(EX_rs2_data), .EX_rd_addr(EX_rd_addr),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_di(dm_di),
    .dm_do(dm_do), .dm_ready(dm_ready), .mem_stall(mem_stall), .mem_misalign(mem_misalign),
    .MEM_MemtoReg(MEM_MemtoReg), .MEM_regWrite(MEM_regWrite), .MEM_rd_data(MEM_rd_data),
    .MEM_Dout(MEM_Dout), .MEM_rd_addr(MEM_rd_addr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic rd, input logic wr, input logic m2r,
                        input logic rw, input logic [2:0] f3, input logic [31:0] alu,
                        input logic [31:0] rs2, input logic [4:0] rda);
    EX_valid = v; EX_MemRead = rd; EX_MemWrite = wr; EX_MemtoReg = m2r; EX_regWrite = rw;
    EX_funct3 = f3; EX_alu_out = alu; EX_rs2_data = rs2; EX_rd_addr = rda;
  endtask

  task automatic set_nop;
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic test_reset;
    rst = 1'b0; set_nop(); dm_ready = 1'b0; dm_do = 32'h0;
    tick(); tick();
    n_cmp++; if (dm_req !== 1'b0) begin n_err++; $display("FAIL rst_dm_req: got %b want 0", dm_req); end
    n_cmp++; if (dm_be !== 4'b0000) begin n_err++; $display("FAIL rst_dm_be: got %b want 0000", dm_be); end
    n_cmp++; if (dm_addr !== 32'h0) begin n_err++; $display("FAIL rst_dm_addr: got %h want 0", dm_addr); end
    n_cmp++; if (MEM_regWrite !== 1'b0) begin n_err++; $display("FAIL rst_mem_rw: got %b want 0", MEM_regWrite); end
    n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", mem_stall); end
    #3 rst = 1'b1;
  endtask

  task automatic test_alu;
    dm_ready = 1'b0;
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
    tick();
    n_cmp++; if (dm_req !== 1'b0) begin n_err++; $display("FAIL alu_req_n: got %b want 0", dm_req); end
    n_cmp++; if (MEM_regWrite !== 1'b0) begin n_err++; $display("FAIL alu_early: got %b want 0", MEM_regWrite); end
    set_nop();
    tick();
    n_cmp++; if (MEM_rd_data !== 32'h0000_1234) begin n_err++; $display("FAIL alu_rd_data: got %h want 00001234", MEM_rd_data); end
    n_cmp++; if (MEM_regWrite !== 1'b1) begin n_err++; $display("FAIL alu_rw: got %b want 1", MEM_regWrite); end
    n_cmp++; if (MEM_rd_addr !== 5'd5) begin n_err++; $display("FAIL alu_rd: got %0d want 5", MEM_rd_addr); end
    n_cmp++; if (MEM_MemtoReg !== 1'b1) begin n_err++; $display("FAIL alu_m2r: got %b want 1", MEM_MemtoReg); end
    n_cmp++; if (dm_req !== 1'b0) begin n_err++; $display("FAIL alu_req_n1: got %b want 0", dm_req); end
  endtask

  task automatic test_loads;
    dm_ready = 1'b1; dm_do = 32'h80FF_0000;
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0, 5'd7);
    tick();
    n_cmp++; if (dm_req !== 1'b1) begin n_err++; $display("FAIL lb_req: got %b want 1", dm_req); end
    n_cmp++; if (dm_addr !== 32'h100) begin n_err++; $display("FAIL lb_addr: got %h want 00000100", dm_addr); end
    n_cmp++; if (dm_be !== 4'b1111) begin n_err++; $display("FAIL lb_be: got %b want 1111", dm_be); end
    n_cmp++; if (dm_we !== 1'b0 || dm_di !== 32'h0) begin n_err++; $display("FAIL lb_we_di: got %b/%h want 0/0", dm_we, dm_di); end
    set_nop();
    tick();
    n_cmp++; if (MEM_Dout !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_dout: got %h want ffffff80", MEM_Dout); end
    n_cmp++; if (MEM_rd_addr !== 5'd7 || MEM_regWrite !== 1'b1) begin n_err++; $display("FAIL lb_wb: got %0d/%b want 7/1", MEM_rd_addr, MEM_regWrite); end
    n_cmp++; if (dm_req !== 1'b0) begin n_err++; $display("FAIL lb_req_drop: got %b want 0", dm_req); end
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 32'h0000_0103, 32'h0, 5'd7);
    tick(); set_nop(); tick();
    n_cmp++; if (MEM_Dout !== 32'h0000_0080) begin n_err++; $display("FAIL lbu_dout: got %h want 00000080", MEM_Dout); end
  endtask

  task automatic test_back_to_back;
    dm_ready = 1'b1; dm_do = 32'h80FF_0000;
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0, 5'd1);
    tick();
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 32'h0000_0103, 32'h0, 5'd2);
    tick();
    n_cmp++; if (dm_req !== 1'b1) begin n_err++; $display("FAIL b2b_req1: got %b want 1", dm_req); end
    n_cmp++; if (MEM_Dout !== 32'hFFFF_FF80) begin n_err++; $display("FAIL b2b_lb: got %h want ffffff80", MEM_Dout); end
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0, 5'd3);
    tick();
    n_cmp++; if (dm_req !== 1'b1) begin n_err++; $display("FAIL b2b_req2: got %b want 1", dm_req); end
    n_cmp++; if (MEM_Dout !== 32'h0000_0080 || MEM_rd_addr !== 5'd2) begin n_err++; $display("FAIL b2b_lbu: got %h/%0d want 00000080/2", MEM_Dout, MEM_rd_addr); end
    set_nop();
    tick();
    n_cmp++; if (MEM_Dout !== 32'hFFFF_80FF) begin n_err++; $display("FAIL b2b_lh: got %h want ffff80ff", MEM_Dout); end
    n_cmp++; if (dm_req !== 1'b0) begin n_err++; $display("FAIL b2b_req_drop: got %b want 0", dm_req); end
  endtask

  task automatic test_stores;
    dm_ready = 1'b1;
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 32'h0000_0022, 32'hABCD_1234, 5'd0);
    tick();
    n_cmp++; if (dm_we !== 1'b1 || dm_req !== 1'b1) begin n_err++; $display("FAIL sh_we_req: got %b/%b want 1/1", dm_we, dm_req); end
    n_cmp++; if (dm_be !== 4'b1100) begin n_err++; $display("FAIL sh_be: got %b want 1100", dm_be); end
    n_cmp++; if (dm_di !== 32'h1234_1234) begin n_err++; $display("FAIL sh_di: got %h want 12341234", dm_di); end
    n_cmp++; if (dm_addr !== 32'h20) begin n_err++; $display("FAIL sh_addr: got %h want 00000020", dm_addr); end
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0021, 32'h0000_0056, 5'd0);
    tick();
    n_cmp++; if (dm_be !== 4'b0010 || dm_di !== 32'h5656_5656) begin n_err++; $display("FAIL sb: got %b/%h want 0010/56565656", dm_be, dm_di); end
    n_cmp++; if (MEM_regWrite !== 1'b0) begin n_err++; $display("FAIL sh_rw: got %b want 0", MEM_regWrite); end
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 32'h0000_0044, 32'hCAFE_F00D, 5'd0);
    tick();
    n_cmp++; if (dm_be !== 4'b1111 || dm_di !== 32'hCAFE_F00D) begin n_err++; $display("FAIL sw: got %b/%h want 1111/cafef00d", dm_be, dm_di); end
    set_nop();
    tick();
  endtask

  task automatic test_wait_states;
    int stalls;
    stalls = 0;
    dm_ready = 1'b0; dm_do = 32'h0;
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_0200, 32'h0, 5'd9);
    tick();
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 32'h0000_0055, 32'h0, 5'd10);
    for (int i = 0; i < 3; i++) begin
      if (mem_stall === 1'b1) stalls++;
      n_cmp++; if (dm_req !== 1'b1 || dm_addr !== 32'h200 || dm_be !== 4'b1111 || dm_we !== 1'b0)
        begin n_err++; $display("FAIL wait_dm_hold[%0d]: got %b/%h/%b/%b want 1/00000200/1111/0", i, dm_req, dm_addr, dm_be, dm_we); end
      tick();
      n_cmp++; if (MEM_regWrite !== 1'b0 || MEM_rd_addr !== 5'd0)
        begin n_err++; $display("FAIL wait_bubble[%0d]: got %b/%0d want 0/0", i, MEM_regWrite, MEM_rd_addr); end
    end
    dm_ready = 1'b1; dm_do = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL wait_stall_end: got %b want 0", mem_stall); end
    n_cmp++; if (stalls !== 3) begin n_err++; $display("FAIL wait_stall_cnt: got %0d want 3", stalls); end
    tick();
    n_cmp++; if (MEM_Dout !== 32'hDEAD_BEEF || MEM_rd_addr !== 5'd9 || MEM_regWrite !== 1'b1)
      begin n_err++; $display("FAIL wait_done: got %h/%0d/%b want deadbeef/9/1", MEM_Dout, MEM_rd_addr, MEM_regWrite); end
    n_cmp++; if (dm_req !== 1'b0) begin n_err++; $display("FAIL wait_req_drop: got %b want 0", dm_req); end
    set_nop();
    tick();
    n_cmp++; if (MEM_rd_data !== 32'h55 || MEM_rd_addr !== 5'd10 || MEM_regWrite !== 1'b1)
      begin n_err++; $display("FAIL wait_add: got %h/%0d/%b want 00000055/10/1", MEM_rd_data, MEM_rd_addr, MEM_regWrite); end
    tick();
    n_cmp++; if (MEM_regWrite !== 1'b0) begin n_err++; $display("FAIL wait_add_once: got %b want 0", MEM_regWrite); end
  endtask

  task automatic test_misalign;
    dm_ready = 1'b1;
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_0102, 32'h0, 5'd3);
    tick();
    n_cmp++; if (dm_req !== 1'b0) begin n_err++; $display("FAIL mis_req: got %b want 0", dm_req); end
    n_cmp++; if (mem_misalign !== 1'b1) begin n_err++; $display("FAIL mis_pulse: got %b want 1", mem_misalign); end
    n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL mis_stall: got %b want 0", mem_stall); end
    set_nop();
    tick();
    n_cmp++; if (mem_misalign !== 1'b0) begin n_err++; $display("FAIL mis_pulse_end: got %b want 0", mem_misalign); end
    n_cmp++; if (MEM_regWrite !== 1'b0) begin n_err++; $display("FAIL mis_rw: got %b want 0", MEM_regWrite); end
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 32'h0000_0101, 32'h0, 5'd3);
    tick();
    n_cmp++; if (mem_misalign !== 1'b1 || dm_req !== 1'b0) begin n_err++; $display("FAIL mis_lh: got %b/%b want 1/0", mem_misalign, dm_req); end
    set_nop();
    tick();
  endtask

  task automatic test_reset_busy;
    dm_ready = 1'b0;
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 32'h0000_0066, 32'h0, 5'd6);
    tick();
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'h0, 5'd8);
    tick();
    n_cmp++; if (dm_req !== 1'b1 || mem_stall !== 1'b1 || MEM_regWrite !== 1'b1)
      begin n_err++; $display("FAIL rb_pre: got %b/%b/%b want 1/1/1", dm_req, mem_stall, MEM_regWrite); end
    set_nop();
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (dm_req !== 1'b0 || dm_addr !== 32'h0) begin n_err++; $display("FAIL rb_dm: got %b/%h want 0/0", dm_req, dm_addr); end
    n_cmp++; if (MEM_regWrite !== 1'b0 || MEM_rd_data !== 32'h0 || MEM_rd_addr !== 5'd0 || MEM_MemtoReg !== 1'b0)
      begin n_err++; $display("FAIL rb_mem: got %b/%h/%0d/%b want 0/0/0/0", MEM_regWrite, MEM_rd_data, MEM_rd_addr, MEM_MemtoReg); end
    n_cmp++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL rb_stall: got %b want 0", mem_stall); end
    #1 rst = 1'b1;
    dm_ready = 1'b1; dm_do = 32'h1122_3344;
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 32'h0000_0077, 32'h0, 5'd4);
    tick();
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'h0, 5'd11);
    tick();
    n_cmp++; if (MEM_rd_data !== 32'h77 || MEM_rd_addr !== 5'd4 || dm_req !== 1'b1)
      begin n_err++; $display("FAIL rb_add: got %h/%0d/%b want 00000077/4/1", MEM_rd_data, MEM_rd_addr, dm_req); end
    set_nop();
    tick();
    n_cmp++; if (MEM_Dout !== 32'h1122_3344 || MEM_rd_addr !== 5'd11)
      begin n_err++; $display("FAIL rb_lw: got %h/%0d want 11223344/11", MEM_Dout, MEM_rd_addr); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_back_to_back();
    test_stores();
    test_wait_states();
    test_misalign();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
